seq_fsm_seg: RTL



---
 rtl/seq_seg_pkg.sv | 27 ++
 rtl/seg7_hex_decoder.sv | 28 ++
 rtl/seq_fsm_seg.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seq_seg_pkg.sv
// Shared constants for the modulo-N sequencer: hex segment table, blank pattern
// and the per-cycle action chosen by the sequencer next-state logic.
package seq_seg_pkg;

  // Bit order {A,B,C,D,E,F,G}, MSB = A, active-high (common cathode).
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [2:0] {
    ACT_HOLD    = 3'd0,
    ACT_RECOVER = 3'd1,
    ACT_LOAD    = 3'd2,
    ACT_UP      = 3'd3,
    ACT_DOWN    = 3'd4
  } seq_act_e;

  function automatic logic [6:0] seg_lookup(input logic [3:0] val);
    return SEG_HEX[val];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-7-segment decoder with blanking and output polarity select.
module seg7_hex_decoder
  import seq_seg_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       valid_i,
  input  logic       active_low_i,
  output logic [6:0] seg_o
);

  logic [6:0] raw_s;

  // Look up the pattern (blank when invalid), then apply display polarity.
  always_comb begin
    raw_s = SEG_BLANK;
    if (valid_i) begin
      raw_s = seg_lookup(val_i);
    end else begin
      raw_s = SEG_BLANK;
    end
    if (active_low_i) begin
      seg_o = ~raw_s;
    end else begin
      seg_o = raw_s;
    end
  end

endmodule

// File: rtl/seq_fsm_seg.sv
// Modulo-N up/down state sequencer with load, level/edge advance, wrap pulse,
// illegal-state recovery and a 7-segment readout of the current state.
module seq_fsm_seg
  import seq_seg_pkg::*;
#(
  parameter int N_STATES       = 6,
  parameter bit EDGE_MODE      = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  localparam int STATE_W       = (N_STATES > 2) ? $clog2(N_STATES) : 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               TH,
  input  logic               DIR,
  input  logic               LOAD,
  input  logic [STATE_W-1:0] LOAD_VAL,
  output logic [STATE_W-1:0] STATE,
  output logic [6:0]         SEG,
  output logic               WRAP
);

  // One extra bit so N_STATES itself is representable when it is a power of two.
  localparam logic [STATE_W:0]   N_EXT = N_STATES[STATE_W:0];
  localparam logic [STATE_W-1:0] LAST  = STATE_W'(N_STATES - 1);
  localparam logic [STATE_W-1:0] ONE   = STATE_W'(1);

  logic [STATE_W-1:0] state_q, state_d;
  logic               wrap_q, wrap_d;
  logic               th_q, th_d;
  logic               adv_s;
  logic               legal_s;
  logic               load_ok_s;
  seq_act_e           act_s;
  logic [3:0]         dec_val_s;

  assign legal_s   = ({1'b0, state_q} < N_EXT);
  assign load_ok_s = ({1'b0, LOAD_VAL} < N_EXT);
  assign th_d      = TH;

  // Advance qualifier: raw level, or rising edge of TH against last cycle's value.
  always_comb begin
    adv_s = 1'b0;
    if (EDGE_MODE) begin
      adv_s = TH & ~th_q;
    end else begin
      adv_s = TH;
    end
  end

  // Prioritised action select: recovery beats load, load beats advance.
  always_comb begin
    act_s = ACT_HOLD;
    if (!legal_s) begin
      act_s = ACT_RECOVER;
    end else if (LOAD) begin
      act_s = ACT_LOAD;
    end else if (adv_s && !DIR) begin
      act_s = ACT_UP;
    end else if (adv_s) begin
      act_s = ACT_DOWN;
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Next state and wrap flag; wrap is decided here so it lines up with the wrapped STATE.
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;
    case (act_s)
      ACT_RECOVER: state_d = '0;
      ACT_LOAD: begin
        if (load_ok_s) begin
          state_d = LOAD_VAL;
        end else begin
          state_d = '0;
        end
      end
      ACT_UP: begin
        if (state_q == LAST) begin
          state_d = '0;
          wrap_d  = 1'b1;
        end else begin
          state_d = state_q + ONE;
        end
      end
      ACT_DOWN: begin
        if (state_q == '0) begin
          state_d = LAST;
          wrap_d  = 1'b1;
        end else begin
          state_d = state_q - ONE;
        end
      end
      ACT_HOLD: state_d = state_q;
      default:  state_d = '0;
    endcase
  end

  // State, wrap and TH history registers.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= '0;
      wrap_q  <= 1'b0;
      th_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_d;
      th_q    <= th_d;
    end
  end

  assign dec_val_s = 4'(state_q);

  seg7_hex_decoder u_dec (
    .val_i        (dec_val_s),
    .valid_i      (legal_s),
    .active_low_i (SEG_ACTIVE_LOW),
    .seg_o        (SEG)
  );

  assign STATE = state_q;
  assign WRAP  = wrap_q;

endmodule
